// File: rtl/ctrl_pkg.sv
// ============================================================================
//  ctrl_pkg : ALU codes, opcode/sub-op constants, state encoding and output
//             bundle shared by the cpu_ctrl_fsm control unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_INC  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NEG  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_DEC  = 3'b110;

  localparam logic [3:0] OP_BR    = 4'b1000;
  localparam logic [3:0] OP_CALL  = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1011;
  localparam logic [3:0] OP_BRC   = 4'b1100;
  localparam logic [3:0] OP_EXT   = 4'b1111;

  localparam logic [2:0] SUB_PUSH = 3'b000;
  localparam logic [2:0] SUB_POP  = 3'b001;
  localparam logic [2:0] SUB_ADD  = 3'b010;
  localparam logic [2:0] SUB_NEG  = 3'b011;
  localparam logic [2:0] SUB_OR   = 3'b100;
  localparam logic [2:0] SUB_NOT  = 3'b101;
  localparam logic [2:0] SUB_RET  = 3'b110;
  localparam logic [2:0] SUB_ILL  = 3'b111;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3, S_F4,
    S_R0, S_R1, S_R2, S_R3, S_R4,
    S_E0, S_E1,
    S_W0, S_W1, S_W2, S_W3, S_W4,
    S_B0, S_B1,
    S_HLT, S_ERR
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_ybuff;
    logic       ld_sp;
    logic       t_pc;
    logic       t_sp;
    logic       t_mar;
    logic       t_mdr;
    logic       t_dbus;
    logic       t_reg;
    logic       t_alu;
    logic       t_ir;
    logic [2:0] func_sel;
    logic [2:0] reg_sel;
    logic       read;
    logic       write;
    logic       halted;
    logic       error;
  } ctrl_out_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_F2) || (s == S_R2) || (s == S_W4);
  endfunction

  function automatic logic [2:0] alu_for_subop(logic [2:0] sub);
    logic [2:0] f;
    f = ALU_PASS;
    case (sub)
      SUB_ADD: f = ALU_ADD;
      SUB_NEG: f = ALU_NEG;
      SUB_OR:  f = ALU_OR;
      SUB_NOT: f = ALU_NOT;
      default: f = ALU_PASS;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mfc_watchdog.sv
// ============================================================================
//  mfc_watchdog : counts consecutive memory-wait cycles and flags expiry when
//                 MFC_TIMEOUT cycles pass without MFC.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module mfc_watchdog #(
  parameter int MFC_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic mfc,
  output logic expired
);

  localparam int CNT_W = (MFC_TIMEOUT < 2) ? 1 : $clog2(MFC_TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Leaving the wait state clears the count, so every entry starts from zero.
  always_comb begin
    count_d = '0;
    if (active) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = active && !mfc && (count_q == CNT_W'(MFC_TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// ============================================================================
//  cpu_ctrl_fsm : Moore control unit sequencing fetch, stack, ALU and branch
//                 micro-steps. Define CTRL_MFC_TIMEOUT_EN for the MFC watchdog.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IR_W-1:0] IR,
  input  logic            status,
  input  logic            MFC,
  output logic            ldMAR,
  output logic            ldMDR,
  output logic            ldIR,
  output logic            ldPC,
  output logic            ldReg,
  output logic            ldYBuff,
  output logic            ldSP,
  output logic            TPC,
  output logic            TSP,
  output logic            TMAR,
  output logic            TMDR,
  output logic            TDBUS,
  output logic            TReg,
  output logic            TALU,
  output logic            TIR,
  output logic [2:0]      funcSelect,
  output logic [2:0]      regSelect,
  output logic            read,
  output logic            write,
  output logic            halted,
  output logic            error
);

  if (IR_W < 10 || MFC_TIMEOUT < 1) begin : g_param_check
    $error("cpu_ctrl_fsm: IR_W must be >= 10 and MFC_TIMEOUT >= 1");
  end

  logic [3:0] opcode;
  logic [2:0] sub_op;
  logic [2:0] reg_fld;

  assign opcode  = IR[IR_W-1  -: 4];
  assign sub_op  = IR[IR_W-5  -: 3];
  assign reg_fld = IR[IR_W-8  -: 3];

  if (IR_W > 10) begin : g_ir_low
    logic unused_ir_low;
    assign unused_ir_low = ^IR[IR_W-11:0];
  end

  state_t    state_q, state_d;
  ctrl_out_t ctrl;
  logic      mfc_timeout;

`ifdef CTRL_MFC_TIMEOUT_EN
  logic wait_active;
  assign wait_active = is_wait_state(state_q);

  mfc_watchdog #(
    .MFC_TIMEOUT (MFC_TIMEOUT)
  ) u_mfc_watchdog (
    .clock   (clock),
    .reset   (reset),
    .active  (wait_active),
    .mfc     (MFC),
    .expired (mfc_timeout)
  );
`else
  assign mfc_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_F0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: if (MFC) state_d = S_F3; else if (mfc_timeout) state_d = S_ERR;
      S_F3: state_d = S_F4;
      S_F4: begin
        state_d = S_ERR;
        case (opcode)
          OP_NOP:  state_d = S_F0;
          OP_CALL: state_d = S_W0;
          OP_BR:   state_d = S_B0;
          OP_BRC:  state_d = status ? S_B0 : S_F0;
          OP_HALT: state_d = S_HLT;
          OP_EXT: begin
            case (sub_op)
              SUB_PUSH:                         state_d = S_W0;
              SUB_POP, SUB_RET, SUB_ADD, SUB_OR: state_d = S_R0;
              SUB_NEG, SUB_NOT:                 state_d = S_E1;
              SUB_ILL:                          state_d = S_ERR;
              default:                          state_d = S_ERR;
            endcase
          end
          default: state_d = S_ERR;
        endcase
      end
      S_R0: state_d = S_R1;
      S_R1: state_d = S_R2;
      S_R2: if (MFC) state_d = S_R3; else if (mfc_timeout) state_d = S_ERR;
      S_R3: state_d = S_R4;
      // Only the two-operand ALU ops need the popped value staged in Y first.
      S_R4: state_d = (sub_op == SUB_ADD || sub_op == SUB_OR) ? S_E0 : S_E1;
      S_E0: state_d = S_E1;
      S_E1: state_d = S_F0;
      S_W0: state_d = S_W1;
      S_W1: state_d = S_W2;
      S_W2: state_d = S_W3;
      S_W3: state_d = S_W4;
      S_W4: begin
        if (MFC)              state_d = (opcode == OP_CALL) ? S_B0 : S_F0;
        else if (mfc_timeout) state_d = S_ERR;
      end
      S_B0:  state_d = S_B1;
      S_B1:  state_d = S_F0;
      S_HLT: state_d = S_HLT;
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    ctrl          = '0;
    ctrl.func_sel = ALU_PASS;
    case (state_q)
      S_F0: ctrl.t_pc = 1'b1;
      S_F1: begin ctrl.t_pc = 1'b1; ctrl.ld_mar = 1'b1; end
      S_F2: begin ctrl.t_mar = 1'b1; ctrl.read = 1'b1; end
      S_F3: begin ctrl.ld_ir = 1'b1; ctrl.t_pc = 1'b1; ctrl.func_sel = ALU_INC; end
      S_F4: begin ctrl.ld_pc = 1'b1; ctrl.t_pc = 1'b1; ctrl.func_sel = ALU_INC; end
      S_R0: ctrl.t_sp = 1'b1;
      S_R1: begin ctrl.t_sp = 1'b1; ctrl.ld_mar = 1'b1; end
      S_R2: begin ctrl.t_mar = 1'b1; ctrl.read = 1'b1; end
      S_R3: begin
        ctrl.t_dbus = 1'b1; ctrl.ld_mdr = 1'b1; ctrl.t_sp = 1'b1; ctrl.func_sel = ALU_INC;
      end
      S_R4: begin ctrl.ld_sp = 1'b1; ctrl.t_sp = 1'b1; ctrl.func_sel = ALU_INC; end
      S_E0: begin ctrl.t_mdr = 1'b1; ctrl.ld_ybuff = 1'b1; end
      S_E1: begin
        case (sub_op)
          SUB_RET: begin ctrl.t_mdr = 1'b1; ctrl.ld_pc = 1'b1; end
          SUB_POP: begin ctrl.t_mdr = 1'b1; ctrl.ld_reg = 1'b1; end
          SUB_NEG, SUB_NOT, SUB_ADD, SUB_OR: begin
            ctrl.t_reg    = 1'b1;
            ctrl.t_alu    = 1'b1;
            ctrl.ld_reg   = 1'b1;
            ctrl.func_sel = alu_for_subop(sub_op);
          end
          default: ;
        endcase
      end
      S_W0: begin ctrl.t_sp = 1'b1; ctrl.func_sel = ALU_DEC; end
      S_W1: begin ctrl.t_sp = 1'b1; ctrl.func_sel = ALU_DEC; ctrl.ld_sp = 1'b1; end
      S_W2: begin ctrl.t_sp = 1'b1; ctrl.ld_mar = 1'b1; end
      S_W3: begin
        ctrl.t_alu  = 1'b1;
        ctrl.ld_mdr = 1'b1;
        // CALL pushes the return address, PUSH pushes the selected register.
        if (opcode == OP_CALL) ctrl.t_pc  = 1'b1;
        else                   ctrl.t_reg = 1'b1;
      end
      S_W4: begin ctrl.t_mdr = 1'b1; ctrl.t_dbus = 1'b1; ctrl.write = 1'b1; end
      S_B0: begin ctrl.t_ir = 1'b1; ctrl.ld_ybuff = 1'b1; end
      S_B1: begin
        ctrl.t_pc = 1'b1; ctrl.t_alu = 1'b1; ctrl.func_sel = ALU_ADD; ctrl.ld_pc = 1'b1;
      end
      S_HLT: ctrl.halted = 1'b1;
      S_ERR: ctrl.error  = 1'b1;
      default: ;
    endcase
    if (ctrl.t_reg || ctrl.ld_reg) ctrl.reg_sel = reg_fld;
    // Outputs are forced quiet for the whole reset pulse, not just from the next edge.
    if (reset) ctrl = '0;
  end

  assign ldMAR      = ctrl.ld_mar;
  assign ldMDR      = ctrl.ld_mdr;
  assign ldIR       = ctrl.ld_ir;
  assign ldPC       = ctrl.ld_pc;
  assign ldReg      = ctrl.ld_reg;
  assign ldYBuff    = ctrl.ld_ybuff;
  assign ldSP       = ctrl.ld_sp;
  assign TPC        = ctrl.t_pc;
  assign TSP        = ctrl.t_sp;
  assign TMAR       = ctrl.t_mar;
  assign TMDR       = ctrl.t_mdr;
  assign TDBUS      = ctrl.t_dbus;
  assign TReg       = ctrl.t_reg;
  assign TALU       = ctrl.t_alu;
  assign TIR        = ctrl.t_ir;
  assign funcSelect = ctrl.func_sel;
  assign regSelect  = ctrl.reg_sel;
  assign read       = ctrl.read;
  assign write      = ctrl.write;
  assign halted     = ctrl.halted;
  assign error      = ctrl.error;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// ============================================================================
//  tb_cpu_ctrl_fsm : directed, table-driven checks of the cpu_ctrl_fsm
//                    micro-step outputs, plus reset and timeout sequences.
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] IR = '0;
  logic        status = 1'b0;
  logic        MFC = 1'b0;
  logic ldMAR, ldMDR, ldIR, ldPC, ldReg, ldYBuff, ldSP;
  logic TPC, TSP, TMAR, TMDR, TDBUS, TReg, TALU, TIR;
  logic [2:0] funcSelect, regSelect;
  logic read, write, halted, error;

  cpu_ctrl_fsm #(.IR_W(16), .MFC_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .IR(IR), .status(status), .MFC(MFC),
    .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR), .ldPC(ldPC), .ldReg(ldReg),
    .ldYBuff(ldYBuff), .ldSP(ldSP), .TPC(TPC), .TSP(TSP), .TMAR(TMAR),
    .TMDR(TMDR), .TDBUS(TDBUS), .TReg(TReg), .TALU(TALU), .TIR(TIR),
    .funcSelect(funcSelect), .regSelect(regSelect), .read(read),
    .write(write), .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  logic [24:0] obs;
  assign obs = {ldMAR, ldMDR, ldIR, ldPC, ldReg, ldYBuff, ldSP,
                TPC, TSP, TMAR, TMDR, TDBUS, TReg, TALU, TIR,
                funcSelect, regSelect, read, write, halted, error};

  localparam logic [24:0] E_LDMAR = 25'd1 << 24;
  localparam logic [24:0] E_LDMDR = 25'd1 << 23;
  localparam logic [24:0] E_LDIR  = 25'd1 << 22;
  localparam logic [24:0] E_LDPC  = 25'd1 << 21;
  localparam logic [24:0] E_LDREG = 25'd1 << 20;
  localparam logic [24:0] E_LDYB  = 25'd1 << 19;
  localparam logic [24:0] E_LDSP  = 25'd1 << 18;
  localparam logic [24:0] E_TPC   = 25'd1 << 17;
  localparam logic [24:0] E_TSP   = 25'd1 << 16;
  localparam logic [24:0] E_TMAR  = 25'd1 << 15;
  localparam logic [24:0] E_TMDR  = 25'd1 << 14;
  localparam logic [24:0] E_TDBUS = 25'd1 << 13;
  localparam logic [24:0] E_TREG  = 25'd1 << 12;
  localparam logic [24:0] E_TALU  = 25'd1 << 11;
  localparam logic [24:0] E_TIR   = 25'd1 << 10;
  localparam logic [24:0] F_INC   = 25'd1 << 7;
  localparam logic [24:0] F_ADD   = 25'd2 << 7;
  localparam logic [24:0] F_DEC   = 25'd6 << 7;
  localparam logic [24:0] E_READ  = 25'd1 << 3;
  localparam logic [24:0] E_WRITE = 25'd1 << 2;
  localparam logic [24:0] E_HALT  = 25'd1 << 1;
  localparam logic [24:0] E_ERR   = 25'd1;

  localparam logic [24:0] X_F0 = E_TPC;
  localparam logic [24:0] X_F1 = E_TPC | E_LDMAR;
  localparam logic [24:0] X_F2 = E_TMAR | E_READ;
  localparam logic [24:0] X_F3 = E_LDIR | E_TPC | F_INC;
  localparam logic [24:0] X_F4 = E_LDPC | E_TPC | F_INC;
  localparam logic [24:0] X_R0 = E_TSP;
  localparam logic [24:0] X_R1 = E_TSP | E_LDMAR;
  localparam logic [24:0] X_R2 = E_TMAR | E_READ;
  localparam logic [24:0] X_R3 = E_TDBUS | E_LDMDR | E_TSP | F_INC;
  localparam logic [24:0] X_R4 = E_LDSP | E_TSP | F_INC;
  localparam logic [24:0] X_E0 = E_TMDR | E_LDYB;
  localparam logic [24:0] X_W0 = E_TSP | F_DEC;
  localparam logic [24:0] X_W1 = E_TSP | F_DEC | E_LDSP;
  localparam logic [24:0] X_W2 = E_TSP | E_LDMAR;
  localparam logic [24:0] X_W4 = E_TMDR | E_TDBUS | E_WRITE;
  localparam logic [24:0] X_B0 = E_TIR | E_LDYB;
  localparam logic [24:0] X_B1 = E_TPC | E_TALU | F_ADD | E_LDPC;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        st;
    logic        mfc;
    logic [24:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [24:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %07h required %07h", name, obs, exp);
    end
  endtask

  task automatic add(input string n, input logic [15:0] ir_v, input logic st_v,
                     input logic mfc_v, input logic [24:0] e);
    vec_t v;
    v.name = n; v.ir = ir_v; v.st = st_v; v.mfc = mfc_v; v.exp = e;
    vq.push_back(v);
  endtask

  // MFC is held high in F0/F1 to show it is ignored outside wait states.
  task automatic add_fetch(input string n, input logic [15:0] ir_v, input logic st_v);
    add({n, " F1"}, ir_v, st_v, 1'b1, X_F1);
    add({n, " F2"}, ir_v, st_v, 1'b1, X_F2);
    add({n, " F3"}, ir_v, st_v, 1'b1, X_F3);
    add({n, " F4"}, ir_v, st_v, 1'b0, X_F4);
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      IR = vq[i].ir; status = vq[i].st; MFC = vq[i].mfc;
      @(posedge clock); #1;
      check(vq[i].name, vq[i].exp);
    end
    vq.delete();
  endtask

  task automatic pulse_reset(input string n);
    #2 reset = 1'b1;
    #1 check({n, " async"}, 25'd0);
    @(negedge clock); reset = 1'b0; MFC = 1'b0;
    #1 check({n, " released F0"}, X_F0);
  endtask

  initial begin
    @(posedge clock); #1;
    check("reset held", 25'd0);
    @(negedge clock); reset = 1'b0;
    #1 check("F0 after reset", X_F0);

    add("nop F1", 16'hA000, 0, 0, X_F1);
    add("nop F2", 16'hA000, 0, 0, X_F2);
    add("nop F2 wait", 16'hA000, 0, 0, X_F2);
    add("nop F3", 16'hA000, 0, 1, X_F3);
    add("nop F4", 16'hA000, 0, 0, X_F4);
    add("nop F0", 16'hA000, 0, 0, X_F0);

    add_fetch("add", 16'hF440, 0);
    add("add R0", 16'hF440, 0, 0, X_R0);
    add("add R1", 16'hF440, 0, 1, X_R1);
    add("add R2", 16'hF440, 0, 0, X_R2);
    add("add R2 wait", 16'hF440, 0, 0, X_R2);
    add("add R3", 16'hF440, 0, 1, X_R3);
    add("add R4", 16'hF440, 0, 0, X_R4);
    add("add E0", 16'hF440, 0, 0, X_E0);
    add("add E1", 16'hF440, 0, 0, E_TREG | E_TALU | E_LDREG | F_ADD | (25'd1 << 4));
    add("add F0", 16'hF440, 0, 0, X_F0);

    add_fetch("call", 16'h9000, 0);
    add("call W0", 16'h9000, 0, 0, X_W0);
    add("call W1", 16'h9000, 0, 0, X_W1);
    add("call W2", 16'h9000, 0, 0, X_W2);
    add("call W3", 16'h9000, 0, 0, E_TALU | E_LDMDR | E_TPC);
    add("call W4", 16'h9000, 0, 0, X_W4);
    add("call W4 wait1", 16'h9000, 0, 0, X_W4);
    add("call W4 wait2", 16'h9000, 0, 0, X_W4);
    add("call B0", 16'h9000, 0, 1, X_B0);
    add("call B1", 16'h9000, 0, 0, X_B1);
    add("call F0", 16'h9000, 0, 0, X_F0);

    add_fetch("push", 16'hF0C0, 0);
    add("push W0", 16'hF0C0, 0, 0, X_W0);
    add("push W1", 16'hF0C0, 0, 0, X_W1);
    add("push W2", 16'hF0C0, 0, 0, X_W2);
    add("push W3", 16'hF0C0, 0, 0, E_TALU | E_LDMDR | E_TREG | (25'd3 << 4));
    add("push W4", 16'hF0C0, 0, 0, X_W4);
    add("push F0", 16'hF0C0, 0, 1, X_F0);

    add_fetch("pop", 16'hF340, 0);
    add("pop R0", 16'hF340, 0, 0, X_R0);
    add("pop R1", 16'hF340, 0, 0, X_R1);
    add("pop R2", 16'hF340, 0, 0, X_R2);
    add("pop R3", 16'hF340, 0, 1, X_R3);
    add("pop R4", 16'hF340, 0, 0, X_R4);
    add("pop E1", 16'hF340, 0, 0, E_TMDR | E_LDREG | (25'd5 << 4));
    add("pop F0", 16'hF340, 0, 0, X_F0);

    add_fetch("brc0", 16'hC000, 0);
    add("brc0 F0", 16'hC000, 0, 0, X_F0);
    add_fetch("brc1", 16'hC000, 1);
    add("brc1 B0", 16'hC000, 1, 0, X_B0);
    add("brc1 B1", 16'hC000, 1, 0, X_B1);
    add("brc1 F0", 16'hC000, 1, 0, X_F0);

    add_fetch("halt", 16'hB000, 0);
    add("halt HLT", 16'hB000, 0, 0, E_HALT);
    add("halt persist", 16'hB000, 0, 1, E_HALT);
    add("halt persist2", 16'h9000, 1, 0, E_HALT);
    run_table();

    pulse_reset("reset in HLT");
    add_fetch("illegal", 16'h2000, 0);
    add("illegal ERR", 16'h2000, 0, 0, E_ERR);
    add("illegal persist", 16'hA000, 0, 1, E_ERR);
    run_table();

    pulse_reset("reset in ERR");
    add_fetch("pop2", 16'hF340, 0);
    add("pop2 R0", 16'hF340, 0, 0, X_R0);
    add("pop2 R1", 16'hF340, 0, 0, X_R1);
    add("pop2 R2", 16'hF340, 0, 0, X_R2);
    run_table();
    #2 reset = 1'b1;
    #1 check("reset mid R2 async", 25'd0);
    @(posedge clock); #1 check("reset mid R2 held", 25'd0);
    @(negedge clock); reset = 1'b0; MFC = 1'b0;
    #1 check("reset mid R2 released F0", X_F0);
    @(posedge clock); #1 check("first fetch F1", X_F1);

`ifdef CTRL_MFC_TIMEOUT_EN
    add("tmo F2 c1", 16'hA000, 0, 0, X_F2);
    add("tmo F2 c2", 16'hA000, 0, 0, X_F2);
    add("tmo F2 c3", 16'hA000, 0, 0, X_F2);
    add("tmo F2 c4", 16'hA000, 0, 0, X_F2);
    add("tmo ERR", 16'hA000, 0, 0, E_ERR);
    add("tmo ERR persist", 16'hA000, 0, 1, E_ERR);
    run_table();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter IR_W, default 16: instruction width; opcode = IR[IR_W-1:IR_W-4], sub-op = IR[IR_W-5:IR_W-7], reg field = IR[IR_W-8:IR_W-10]; SHALL be at least 10.
REQ-002 Parameter MFC_TIMEOUT, default 15: maximum number of wait cycles for MFC, used when the timeout feature (REQ-024) is compiled in.
REQ-003 clock  in  1  sole clock; all state changes occur on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 IR  in  IR_W  current instruction; stable from the cycle after ldIR.
REQ-006 status  in  1  condition flag for conditional branch.
REQ-007 MFC  in  1  memory-function-complete, sampled in the memory wait states.
REQ-008 ldMAR, ldMDR, ldIR, ldPC, ldReg, ldYBuff, ldSP  out  1 each  register load strobes.
REQ-009 TPC, TSP, TMAR, TMDR, TDBUS, TReg, TALU, TIR  out  1 each  bus tri-state enables.
REQ-010 funcSelect  out  3  ALU op; regSelect  out  3  register-bank index; read, write  out  1  memory strobes.
REQ-011 halted  out  1  HALT executed; error  out  1  illegal opcode or memory timeout.

Function
REQ-012 The block SHALL be a Moore machine: outputs are decoded from the state register and IR only; unlisted outputs are 0 and funcSelect defaults to PASS.
REQ-013 Each ld* strobe SHALL be high for exactly one full clock cycle.
REQ-014 Fetch: F0 TPC; F1 TPC,ldMAR; F2 TMAR,read, hold until MFC=1; F3 ldIR,TPC,INC; F4 ldPC,TPC,INC, then dispatch.
REQ-015 Dispatch: 1010 NOP->F0; 1111/000 PUSH and 1001 CALL->W0; 1111/001 POP and 1111/110 RET->R0; 1111/011 NEG, 1111/101 NOT->E1; 1111/010 ADD, 1111/100 OR->R0; 1000 BR->B0; 1100 BRC->B0 if status=1, else F0; 1011 HALT->HLT; any other opcode or sub-op 111->ERR.
REQ-016 Stack read: R0 TSP; R1 TSP,ldMAR; R2 TMAR,read, hold until MFC; R3 TDBUS,ldMDR,TSP,INC; R4 ldSP,TSP,INC; then E0 for ADD/OR, else E1.
REQ-017 E0 (ADD/OR): TMDR,ldYBuff. E1: RET -> TMDR,PASS,ldPC; POP -> TMDR,PASS,ldReg; NEG/NOT/ADD/OR -> TReg,TALU,ldReg, funcSelect = sub-op; then F0.
REQ-018 regSelect SHALL equal the IR reg field in every state that asserts TReg or ldReg, and be 0 otherwise.
REQ-019 Stack write: W0 TSP,DEC; W1 TSP,DEC,ldSP; W2 TSP,ldMAR; W3 TALU,ldMDR,PASS, plus TReg (PUSH) or TPC (CALL); W4 TMDR,TDBUS,write, hold until MFC; PUSH->F0, CALL->B0.
REQ-020 Branch: B0 TIR,ldYBuff; B1 TPC,TALU,ADD,ldPC; then F0.
REQ-021 HLT and ERR SHALL be absorbing states, asserting halted or error respectively, until reset.
REQ-022 MFC outside wait states SHALL be ignored; MFC asserted on the cycle a wait state is entered SHALL complete it on that edge (minimum one wait cycle).

Reset
REQ-023 On reset (including mid-transfer): state F0, all strobes, enables, read, write, halted and error = 0, funcSelect = regSelect = 0, wait counter = 0; the first fetch SHALL begin on the first rising edge after reset is released.

Configuration
REQ-024 CTRL_MFC_TIMEOUT_EN defined: a counter SHALL run in F2/R2/W4, cleared on entry; MFC_TIMEOUT cycles without MFC -> ERR, with read/write dropped on that edge. Undefined: wait states hold indefinitely and no counter logic exists.

Structure
REQ-025 Package ctrl_pkg SHALL hold the ALU codes (PASS 000, INC 001, ADD 010, NEG 011, OR 100, NOT 101, DEC 110), opcode/sub-op constants and the state enum.
REQ-026 The timeout counter SHALL be the sub-module mfc_watchdog, instantiated only under CTRL_MFC_TIMEOUT_EN.

Verification
REQ-027 Reset, then IR=A000 with MFC after 2 cycles -> F0..F4 sequence, single-cycle ldIR and ldPC, return to F0.
REQ-028 IR=F440 (ADD r1) -> R0..R4, E0 ldYBuff, E1 funcSelect=010, regSelect=001, ldReg one cycle.
REQ-029 IR=9000 (CALL) -> W0..W4 with funcSelect=110 in W0/W1, write held until MFC, then B0/B1 with ldPC.
REQ-030 IR=C000 with status=0 -> F0 after F4; with status=1 -> B0/B1 executed.
REQ-031 IR=B000 -> halted=1 persists; IR=2000 -> error=1; reset asserted mid-R2 -> all outputs 0 immediately.
REQ-032 CTRL_MFC_TIMEOUT_EN, MFC_TIMEOUT=4, MFC never asserted -> error=1 and read=0 after 4 wait cycles.
